// File: rtl/vxe_vpu_cmd_disp.sv
// VPU command dispatcher: pops show-ahead FIFO commands and issues them one at a time
// to the register update ECU or the vector execute ECU, with per-thread ordering and SYNC.
module vxe_vpu_cmd_disp (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vld,
  output logic        o_rd,
  input  logic [4:0]  i_op,
  input  logic [2:0]  i_th,
  input  logic [47:0] i_pl,
  output logic [4:0]  o_cmd_op,
  output logic [2:0]  o_cmd_th,
  output logic [47:0] o_cmd_pl,
  output logic        o_regu_disp,
  input  logic        i_regu_done,
  output logic        o_exec_disp,
  input  logic        i_exec_done,
  output logic        o_sync,
  output logic        o_busy,
  output logic        o_err
);

  // Opcode encodings mirror vxe_ctrl_unit_cmds.vh
  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_SETACC = 5'h01;
  localparam logic [4:0] OP_SETVL  = 5'h02;
  localparam logic [4:0] OP_SETEN  = 5'h03;
  localparam logic [4:0] OP_SETRS  = 5'h04;
  localparam logic [4:0] OP_SETRT  = 5'h05;
  localparam logic [4:0] OP_SETRD  = 5'h06;
  localparam logic [4:0] OP_PROD   = 5'h08;
  localparam logic [4:0] OP_STORE  = 5'h09;
  localparam logic [4:0] OP_SYNC   = 5'h0F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RWAIT = 2'd1,
    S_SYNC  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_exec_busy;
  logic [2:0]  r_exec_th;
  logic [4:0]  r_cmd_op;
  logic [2:0]  r_cmd_th;
  logic [47:0] r_cmd_pl;
  logic        r_regu_disp;
  logic        r_exec_disp;
  logic        r_sync;
  logic        r_err;

  logic        w_is_regu;
  logic        w_is_exec;
  logic        w_is_nop;
  logic        w_is_sync;
  logic        w_eval;
  logic        w_rd;
  logic        w_acc_regu;
  logic        w_acc_exec;
  logic        w_acc_bad;
  logic        w_sync_set;

  always_comb begin
    w_is_regu = 1'b0;
    w_is_exec = 1'b0;
    w_is_nop  = 1'b0;
    w_is_sync = 1'b0;
    case (i_op)
      OP_SETACC, OP_SETVL, OP_SETEN,
      OP_SETRS, OP_SETRT, OP_SETRD: w_is_regu = 1'b1;
      OP_PROD, OP_STORE:            w_is_exec = 1'b1;
      OP_NOP:                       w_is_nop  = 1'b1;
      OP_SYNC:                      w_is_sync = 1'b1;
      default:                      ;
    endcase
  end

  // A regu done frees the dispatcher in the same cycle, so RWAIT+done behaves as IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_acc_regu  = 1'b0;
    w_acc_exec  = 1'b0;
    w_acc_bad   = 1'b0;
    w_sync_set  = 1'b0;
    w_eval      = (r_state == S_IDLE) || ((r_state == S_RWAIT) && i_regu_done);

    case (r_state)
      S_RWAIT: if (i_regu_done) w_state_nxt = S_IDLE;
      S_SYNC: begin
        if (!r_exec_busy) begin
          w_sync_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: ;
    endcase

    if (w_eval && i_vld && !rst) begin
      if (w_is_nop) begin
        w_rd = 1'b1;
      end else if (w_is_regu) begin
        if (!(r_exec_busy && (i_th == r_exec_th))) begin
          w_rd        = 1'b1;
          w_acc_regu  = 1'b1;
          w_state_nxt = S_RWAIT;
        end
      end else if (w_is_exec) begin
        if (!r_exec_busy) begin
          w_rd       = 1'b1;
          w_acc_exec = 1'b1;
        end
      end else if (w_is_sync) begin
        w_rd        = 1'b1;
        w_state_nxt = S_SYNC;
      end else begin
        w_rd      = 1'b1;
        w_acc_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_exec_busy <= 1'b0;
      r_exec_th   <= '0;
      r_cmd_op    <= '0;
      r_cmd_th    <= '0;
      r_cmd_pl    <= '0;
      r_regu_disp <= 1'b0;
      r_exec_disp <= 1'b0;
      r_sync      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_regu_disp <= w_acc_regu;
      r_exec_disp <= w_acc_exec;
      r_sync      <= w_sync_set;
      if (w_acc_exec) begin
        r_exec_busy <= 1'b1;
        r_exec_th   <= i_th;
      end else if (i_exec_done) begin
        r_exec_busy <= 1'b0;
      end
      // Bus only moves on an accept, so it stays put while a regu command is outstanding
      if (w_acc_regu || w_acc_exec) begin
        r_cmd_op <= i_op;
        r_cmd_th <= i_th;
        r_cmd_pl <= i_pl;
      end
      if (w_acc_bad) r_err <= 1'b1;
    end
  end

  assign o_rd        = w_rd;
  assign o_cmd_op    = r_cmd_op;
  assign o_cmd_th    = r_cmd_th;
  assign o_cmd_pl    = r_cmd_pl;
  assign o_regu_disp = r_regu_disp;
  assign o_exec_disp = r_exec_disp;
  assign o_sync      = r_sync;
  assign o_err       = r_err;
  assign o_busy      = (r_state != S_IDLE) || r_exec_busy || r_regu_disp || r_exec_disp;

endmodule
